// File: rtl/mul32_seq_ctrl.sv
// mul32_seq_ctrl
// Sequential 32x32 -> 64 unsigned multiplier controller. It drives an external
// combinational 32x8 multiplier one B byte per cycle and accumulates the
// shifted partial products.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-high reset
//   start_valid  in   1   requester presents operands
//   start_ready  out  1   operands accepted this cycle (IDLE only)
//   a, b         in   32  unsigned operands
//   mul_a        out  32  operand A to external multiplier (0 outside RUN)
//   mul_b        out  8   current B byte to external multiplier (0 outside RUN)
//   mul_y        in   40  mul_a * mul_b from external multiplier
//   res_valid    out  1   product valid (DONE)
//   res_ready    in   1   consumer takes product
//   product      out  64  accumulator, meaningful while res_valid
//   busy         out  1   high in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// RUN   | one B byte per cycle accumulated into acc
// DONE  | product held until res_ready
module mul32_seq_ctrl #(
    parameter int unsigned EARLY_TERM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] mul_a,
    output logic [7:0]  mul_b,
    input  logic [39:0] mul_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_acc;
    logic [1:0]  r_idx;
    logic [31:0] r_a;
    logic [31:0] r_b;

    logic [7:0]  w_slice;
    logic        w_upper_zero;
    logic        w_last;
    logic [63:0] w_partial;

    // Current B byte and whether every byte above it is zero.
    always_comb begin
        w_slice      = r_b[7:0];
        w_upper_zero = 1'b1;
        case (r_idx)
            2'd0: begin
                w_slice      = r_b[7:0];
                w_upper_zero = (r_b[31:8] == 24'd0);
            end
            2'd1: begin
                w_slice      = r_b[15:8];
                w_upper_zero = (r_b[31:16] == 16'd0);
            end
            2'd2: begin
                w_slice      = r_b[23:16];
                w_upper_zero = (r_b[31:24] == 8'd0);
            end
            default: begin
                w_slice      = r_b[31:24];
                w_upper_zero = 1'b1;
            end
        endcase
    end

    assign w_last    = (r_idx == 2'd3) || ((EARLY_TERM != 0) && w_upper_zero);
    assign w_partial = {24'd0, mul_y} << {r_idx, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        mul_a       = 32'd0;
        mul_b       = 8'd0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                mul_a = r_a;
                mul_b = w_slice;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
                busy   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 64'd0;
            r_idx <= 2'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (start_valid) begin
                r_a   <= a;
                r_b   <= b;
                r_acc <= 64'd0;
                r_idx <= 2'd0;
            end
        end else if (r_state == S_RUN) begin
            r_acc <= r_acc + w_partial;
            r_idx <= r_idx + 2'd1;
        end
    end

    assign product = r_acc;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
module tb_mul32_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        res_ready;

    // u1: EARLY_TERM=1, u0: EARLY_TERM=0, sharing all requester-side inputs
    logic        sr1, rv1, busy1, sr0, rv0, busy0;
    logic [31:0] ma1, ma0;
    logic [7:0]  mb1, mb0;
    logic [39:0] my1, my0;
    logic [63:0] prod1, prod0;

    assign my1 = {8'd0, ma1} * {32'd0, mb1};
    assign my0 = {8'd0, ma0} * {32'd0, mb0};

    mul32_seq_ctrl #(.EARLY_TERM(1)) u1 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr1),
        .a(a), .b(b), .mul_a(ma1), .mul_b(mb1), .mul_y(my1),
        .res_valid(rv1), .res_ready(res_ready), .product(prod1), .busy(busy1)
    );

    mul32_seq_ctrl #(.EARLY_TERM(0)) u0 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr0),
        .a(a), .b(b), .mul_a(ma0), .mul_b(mb0), .mul_y(my0),
        .res_valid(rv0), .res_ready(res_ready), .product(prod0), .busy(busy0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int kmodel(input logic [31:0] bv);
        if (bv[31:24] != 8'd0)      return 4;
        else if (bv[23:16] != 8'd0) return 3;
        else if (bv[15:8] != 8'd0)  return 2;
        else                        return 1;
    endfunction

    typedef struct {
        logic [63:0] prod;
        int          k;
        int          edge_n;
    } sb_t;

    sb_t q1[$];
    sb_t q0[$];
    logic [63:0] cur_exp = 64'd0;
    int          cur_k1  = 1;
    bit          seen1 = 0, seen0 = 0;
    int          done1 = -100, done0 = -100;
    int          gap1 = 0, gap0 = 0;
    int          n_acc1 = 0, n_acc0 = 0;

    // Scoreboard monitors: push at start handshake, check latency on the first
    // res_valid cycle, check product every valid cycle, pop on result handshake.
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            seen1 = 0;
        end else begin
            if (start_valid && sr1) begin
                q1.push_back(sb_t'{cur_exp, cur_k1, cyc + 1});
                gap1 = cyc + 1 - done1;
                n_acc1++;
            end
            if (rv1) begin
                if (q1.size() == 0) begin
                    chk("et1_res_valid_without_op", 64'(rv1), 64'd0);
                end else begin
                    if (!seen1) begin
                        chk("et1_latency", 64'(cyc - q1[0].edge_n), 64'(q1[0].k));
                        seen1 = 1;
                    end
                    chk("et1_product", prod1, q1[0].prod);
                    if (res_ready) begin
                        void'(q1.pop_front());
                        seen1 = 0;
                        done1 = cyc + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            seen0 = 0;
        end else begin
            if (start_valid && sr0) begin
                q0.push_back(sb_t'{cur_exp, 4, cyc + 1});
                gap0 = cyc + 1 - done0;
                n_acc0++;
            end
            if (rv0) begin
                if (q0.size() == 0) begin
                    chk("et0_res_valid_without_op", 64'(rv0), 64'd0);
                end else begin
                    if (!seen0) begin
                        chk("et0_latency", 64'(cyc - q0[0].edge_n), 64'(q0[0].k));
                        seen0 = 1;
                    end
                    chk("et0_product", prod0, q0[0].prod);
                    if (res_ready) begin
                        void'(q0.pop_front());
                        seen0 = 0;
                        done0 = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int pending;
        pending = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            pending = q0.size() + q1.size();
            if (pending == 0) break;
        end
        chk({name, "_pending_ops"}, 64'(pending), 64'd0);
        chk({name, "_ready_after"}, {62'd0, sr1, sr0}, 64'd3);
    endtask

    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] ev, input int k1);
        @(posedge clk);
        #1;
        a           = av;
        b           = bv;
        cur_exp     = ev;
        cur_k1      = k1;
        res_ready   = 1'b1;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_idle("op");
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_start_ready"}, {62'd0, sr1, sr0}, 64'd3);
        chk({name, "_res_valid"},   {62'd0, rv1, rv0}, 64'd0);
        chk({name, "_busy"},        {62'd0, busy1, busy0}, 64'd0);
        chk({name, "_product"},     prod1 | prod0, 64'd0);
        chk({name, "_mul_a"},       {ma1, ma0}, 64'd0);
        chk({name, "_mul_b"},       {48'd0, mb1, mb0}, 64'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        int          k1;
    } vec_t;

    vec_t        tbl[8];
    logic [31:0] masks[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int          base;

        tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 4};
        tbl[1] = '{32'h12345678, 32'h00000003, 64'h00000000369D0368, 1};
        tbl[2] = '{32'h12345678, 32'h00010000, 64'h0000123456780000, 3};
        tbl[3] = '{32'hDEADBEEF, 32'h00000000, 64'h0000000000000000, 1};
        tbl[4] = '{32'h00000007, 32'h00000009, 64'h000000000000003F, 1};
        tbl[5] = '{32'h00000001, 32'h01000000, 64'h0000000001000000, 4};
        tbl[6] = '{32'h00000010, 32'h00000100, 64'h0000000000001000, 2};
        tbl[7] = '{32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, 4};
        masks[0] = 32'h00000000;
        masks[1] = 32'h000000FF;
        masks[2] = 32'h0000FFFF;
        masks[3] = 32'h00FFFFFF;
        masks[4] = 32'hFFFFFFFF;

        rst         = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a           = 32'd0;
        b           = 32'd0;

        @(negedge clk);
        check_reset_outputs("reset_held");
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_released");

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].prod, tbl[i].k1);
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom & masks[$urandom_range(0, 4)];
            do_op(ra, rb, 64'(ra) * 64'(rb), kmodel(rb));
        end

        // Result held off for 10 cycles while a new request is presented.
        @(posedge clk);
        #1;
        a           = 32'hCAFEBABE;
        b           = 32'h80000001;
        cur_exp     = 64'(32'hCAFEBABE) * 64'(32'h80000001);
        cur_k1      = 4;
        res_ready   = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        a       = 32'h11111111;
        b       = 32'h22222222;
        cur_exp = 64'd0;
        for (int i = 0; i < 10; i++) begin
            if (rv1 && rv0) break;
            @(posedge clk);
            #1;
        end
        chk("hold_reached_done", {62'd0, rv1, rv0}, 64'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_res_valid",   {62'd0, rv1, rv0}, 64'd3);
            chk("hold_start_ready", {62'd0, sr1, sr0}, 64'd0);
            chk("hold_busy",        {62'd0, busy1, busy0}, 64'd3);
            chk("hold_mul_ab",      {ma1 | ma0, 24'd0, mb1 | mb0}, 64'd0);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        res_ready   = 1'b1;
        wait_idle("hold");

        // Asynchronous reset while the third byte is being processed.
        @(posedge clk);
        #1;
        a           = 32'h01020304;
        b           = 32'h44332211;
        cur_exp     = 64'(32'h01020304) * 64'(32'h44332211);
        cur_k1      = 4;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_mid_run_slice2", {48'd0, mb1, mb0}, 64'h3333);
        chk("rst_mid_run_busy",   {62'd0, busy1, busy0}, 64'd3);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
        end
        chk("rst_after_no_valid",  {62'd0, rv1, rv0}, 64'd0);
        chk("rst_after_ready",     {62'd0, sr1, sr0}, 64'd3);
        do_op(32'd7, 32'd9, 64'd63, 1);

        // Back-to-back: second request accepted one cycle after DONE handshake.
        base = n_acc1;
        @(posedge clk);
        #1;
        a           = 32'h89ABCDEF;
        b           = 32'h87654321;
        cur_exp     = 64'(32'h89ABCDEF) * 64'(32'h87654321);
        cur_k1      = 4;
        res_ready   = 1'b1;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        a       = 32'hFFFFFFFF;
        b       = 32'h80000000;
        cur_exp = 64'(32'hFFFFFFFF) * 64'(32'h80000000);
        for (int i = 0; i < 20; i++) begin
            if (n_acc1 == base + 2) break;
            @(posedge clk);
            #1;
        end
        start_valid = 1'b0;
        chk("b2b_second_accepted", 64'(n_acc1 - base), 64'd2);
        chk("b2b_gap_et1", 64'(gap1), 64'd1);
        chk("b2b_gap_et0", 64'(gap0), 64'd1);
        wait_idle("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
